dsp_mac_pipe: RTL and testbench

- Parametrised successor of the fixed-width DSP slice: a signed/unsigned multiply-accumulate pipeline with configurable operand widths and register depth.
- Adds what the previous slice lacks: a valid-tagged pipeline with per-sample opmode, a global stall (ce), saturating arithmetic and overflow flags (per-sample and sticky).
- Sits in datapaths (FIR taps, dot products) where the caller streams samples and reads accumulated results with a fixed, known latency.

---
 rtl/dsp_mac_pipe.sv | 197 +++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: parametrised multiply-accumulate pipeline.
// Flow: input register stages (AREG) -> product stage (MREG) -> P stage (always registered).
// Each sample carries its valid bit, opmode and addend through the pipe.
// The accumulator feedback lives only in the P stage, so it is a single-cycle loop at any latency.
module dsp_mac_pipe #(
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 18,
    parameter int P_WIDTH  = 48,
    parameter int AREG     = 1,
    parameter int MREG     = 1,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    input  logic [P_WIDTH-1:0] c,
    input  logic [2:0]         opmode,
    input  logic               ovf_clr,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] p,
    output logic               ovf,
    output logic               ovf_sticky
);

    localparam int AB_W = A_WIDTH + B_WIDTH;
    localparam int X_W  = P_WIDTH + 2;
    localparam int IN_W = 1 + 3 + P_WIDTH + B_WIDTH + A_WIDTH;
    localparam int M_W  = 1 + 3 + P_WIDTH + AB_W;
    localparam logic SGN = (SIGNED != 0);
    localparam logic SAT = (SATURATE != 0);
    localparam logic [P_WIDTH-1:0] S_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};
    localparam logic [P_WIDTH-1:0] S_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};

    generate
        if (P_WIDTH < AB_W) begin : g_bad_pwidth
            $error("dsp_mac_pipe: P_WIDTH must be >= A_WIDTH + B_WIDTH");
        end
        if (AREG < 0 || AREG > 2) begin : g_bad_areg
            $error("dsp_mac_pipe: AREG must be 0, 1 or 2");
        end
        if (MREG < 0 || MREG > 1) begin : g_bad_mreg
            $error("dsp_mac_pipe: MREG must be 0 or 1");
        end
    endgenerate

    // ---------------- input register stages ----------------
    logic [IN_W-1:0] in_bus;
    logic [IN_W-1:0] s1_bus;
    assign in_bus = {in_valid, opmode, c, b, a};

    generate
        if (AREG == 0) begin : g_areg_none
            assign s1_bus = in_bus;
        end else begin : g_areg
            for (genvar gi = 0; gi < AREG; gi++) begin : g_stage
                logic [IN_W-1:0] stage_q;
                logic [IN_W-1:0] stage_d;
                if (gi == 0) begin : g_first
                    assign stage_d = in_bus;
                end else begin : g_chain
                    assign stage_d = g_stage[gi-1].stage_q;
                end
                // Input delay stage: the whole sample bundle shifts one step per ce.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_q <= '0;
                    end else if (ce) begin
                        stage_q <= stage_d;
                    end
                end
            end
            assign s1_bus = g_stage[AREG-1].stage_q;
        end
    endgenerate

    logic               s1_valid;
    logic [2:0]         s1_op;
    logic [P_WIDTH-1:0] s1_c;
    logic [B_WIDTH-1:0] s1_b;
    logic [A_WIDTH-1:0] s1_a;
    assign {s1_valid, s1_op, s1_c, s1_b, s1_a} = s1_bus;

    // ---------------- multiplier ----------------
    // Operands are extended to the full product width first, so the low AB_W bits
    // of the product are exact for both signed and unsigned operation.
    logic [AB_W-1:0] a_ext;
    logic [AB_W-1:0] b_ext;
    logic [AB_W-1:0] prod_d;
    assign a_ext  = {{B_WIDTH{SGN & s1_a[A_WIDTH-1]}}, s1_a};
    assign b_ext  = {{A_WIDTH{SGN & s1_b[B_WIDTH-1]}}, s1_b};
    assign prod_d = a_ext * b_ext;

    logic [M_W-1:0] m_bus_d;
    logic [M_W-1:0] m_bus;
    assign m_bus_d = {s1_valid, s1_op, s1_c, prod_d};

    generate
        if (MREG == 0) begin : g_mreg_none
            assign m_bus = m_bus_d;
        end else begin : g_mreg
            logic [M_W-1:0] m_bus_q;
            // Product stage: product travels with its valid, opmode and addend.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_bus_q <= '0;
                end else if (ce) begin
                    m_bus_q <= m_bus_d;
                end
            end
            assign m_bus = m_bus_q;
        end
    endgenerate

    logic               m_valid;
    logic [2:0]         m_op;
    logic [P_WIDTH-1:0] m_c;
    logic [AB_W-1:0]    m_prod;
    assign {m_valid, m_op, m_c, m_prod} = m_bus;

    // ---------------- P stage ----------------
    logic               out_valid_q;
    logic [P_WIDTH-1:0] p_q;
    logic               ovf_q;
    logic               ovf_sticky_q;

    logic [X_W-1:0]     m_x;
    logic [X_W-1:0]     c_x;
    logic [X_W-1:0]     p_x;
    logic [X_W-1:0]     sum_x;
    logic               ovf_d;
    logic [P_WIDTH-1:0] sat_val;
    logic [P_WIDTH-1:0] p_d;

    // Opmode decode; two guard bits keep the exact sum so overflow is detectable.
    always_comb begin
        m_x   = {{(X_W-AB_W){SGN & m_prod[AB_W-1]}}, m_prod};
        c_x   = {{2{SGN & m_c[P_WIDTH-1]}}, m_c};
        p_x   = {{2{SGN & p_q[P_WIDTH-1]}}, p_q};
        sum_x = m_x;
        case (m_op)
            3'b001:  sum_x = m_x + c_x;
            3'b010:  sum_x = p_x + m_x;
            3'b011:  sum_x = p_x - m_x;
            3'b100:  sum_x = c_x;
            3'b101:  sum_x = '0;
            default: sum_x = m_x;
        endcase
    end

    // Range check and clamp/wrap; the top guard bit tells which bound was crossed.
    always_comb begin
        if (SGN) begin
            ovf_d   = !((&sum_x[X_W-1:P_WIDTH-1]) || !(|sum_x[X_W-1:P_WIDTH-1]));
            sat_val = sum_x[X_W-1] ? S_MIN : S_MAX;
        end else begin
            ovf_d   = |sum_x[X_W-1:P_WIDTH];
            sat_val = sum_x[X_W-1] ? '0 : '1;
        end
        p_d = (ovf_d && SAT) ? sat_val : sum_x[P_WIDTH-1:0];
    end

    // Result register: bubbles leave p and ovf untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
        end else if (ce) begin
            out_valid_q <= m_valid;
            if (m_valid) begin
                p_q   <= p_d;
                ovf_q <= ovf_d;
            end
        end
    end

    // Sticky overflow: a new overflow beats a simultaneous clear; the clear ignores ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
        end else if (ce && m_valid && ovf_d) begin
            ovf_sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign p          = p_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: three instances (48-bit saturating, 36-bit saturating,
// 36-bit wrapping) share one stimulus stream; a sample-level model predicts
// every output slot and a falling-edge process compares all of them.
module tb_dsp_mac_pipe;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [17:0] a = '0;
    logic [17:0] b = '0;
    logic [47:0] c = '0;
    logic [2:0]  opmode = '0;

    logic [2:0]  ov_w;
    logic [2:0]  ovf_w;
    logic [2:0]  stk_w;
    logic [47:0] p0;
    logic [35:0] p1;
    logic [35:0] p2;
    longint      dp [3];

    always #5 clk = ~clk;

    dsp_mac_pipe u_def (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .opmode(opmode), .ovf_clr(ovf_clr),
        .out_valid(ov_w[0]), .p(p0), .ovf(ovf_w[0]), .ovf_sticky(stk_w[0])
    );

    dsp_mac_pipe #(.P_WIDTH(36), .SATURATE(1)) u_sat36 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .c(c[35:0]), .opmode(opmode), .ovf_clr(ovf_clr),
        .out_valid(ov_w[1]), .p(p1), .ovf(ovf_w[1]), .ovf_sticky(stk_w[1])
    );

    dsp_mac_pipe #(.P_WIDTH(36), .SATURATE(0)) u_wrap36 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .c(c[35:0]), .opmode(opmode), .ovf_clr(ovf_clr),
        .out_valid(ov_w[2]), .p(p2), .ovf(ovf_w[2]), .ovf_sticky(stk_w[2])
    );

    always_comb begin
        dp[0] = longint'($signed(p0));
        dp[1] = longint'($signed(p1));
        dp[2] = longint'($signed(p2));
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- sample-level model ----------------
    typedef struct packed {
        int              due;
        logic [2:0][63:0] v;
        logic [2:0]       o;
    } exp_t;

    exp_t       q [$];
    longint     mp [3];
    longint     last_p [3];
    bit         last_o [3];
    bit         stk [3];
    int         n = 0;
    logic [2:0] pin_en = '0;
    longint     pin_v [3];

    // Result of the sample on the inputs for instance i, from the opmode rules.
    function automatic void model(input int i, output longint r, output bit o);
        int     pw;
        bit     st;
        longint m, cc, s, mx, mn;
        pw = (i == 0) ? 48 : 36;
        st = (i != 2);
        m  = longint'($signed(a)) * longint'($signed(b));
        cc = longint'(c);
        cc = (cc <<< (64 - pw)) >>> (64 - pw);
        mx = (longint'(1) <<< (pw - 1)) - 1;
        mn = -mx - 1;
        case (opmode)
            3'b001:  s = m + cc;
            3'b010:  s = mp[i] + m;
            3'b011:  s = mp[i] - m;
            3'b100:  s = cc;
            3'b101:  s = 0;
            default: s = m;
        endcase
        o = (s > mx) || (s < mn);
        if (!o)      r = s;
        else if (st) r = (s > mx) ? mx : mn;
        else         r = (s <<< (64 - pw)) >>> (64 - pw);
    endfunction

    // Every falling edge: compare all outputs, then advance the model for the coming edge.
    always @(negedge clk) begin
        exp_t   e;
        bit     ev;
        longint r;
        bit     o;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                check("rst_out_valid", ov_w[i], 0);
                check("rst_p", dp[i], 0);
                check("rst_ovf", ovf_w[i], 0);
                check("rst_sticky", stk_w[i], 0);
                mp[i] = 0; last_p[i] = 0; last_o[i] = 0; stk[i] = 0;
            end
            q.delete();
        end else begin
            ev = (q.size() > 0) && (q[0].due == n);
            for (int i = 0; i < 3; i++) begin
                check("out_valid", ov_w[i], ev);
                check("p", dp[i], ev ? longint'(q[0].v[i]) : last_p[i]);
                check("ovf", ovf_w[i], ev ? q[0].o[i] : last_o[i]);
                check("ovf_sticky", stk_w[i], stk[i]);
            end
            if (ce && ev) begin
                for (int i = 0; i < 3; i++) begin
                    last_p[i] = longint'(q[0].v[i]);
                    last_o[i] = q[0].o[i];
                end
                void'(q.pop_front());
            end
            for (int i = 0; i < 3; i++) begin
                if (ce && q.size() > 0 && q[0].due == n + 1 && q[0].o[i]) stk[i] = 1;
                else if (ovf_clr) stk[i] = 0;
            end
            if (ce && in_valid) begin
                e.due = n + L;
                for (int i = 0; i < 3; i++) begin
                    model(i, r, o);
                    if (pin_en[i]) check("model_pin", r, pin_v[i]);
                    e.v[i] = r;
                    e.o[i] = o;
                    mp[i]  = r;
                end
                q.push_back(e);
            end
            if (ce) n++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic ce_i, input int av, input int bv,
                         input longint cv, input logic [2:0] op, input logic clr,
                         input logic [2:0] pe, input longint v0, input longint v1, input longint v2);
        longint cl;
        cl       = cv;
        in_valid = v;
        ce       = ce_i;
        a        = av[17:0];
        b        = bv[17:0];
        c        = cl[47:0];
        opmode   = op;
        ovf_clr  = clr;
        pin_en   = pe;
        pin_v[0] = v0;
        pin_v[1] = v1;
        pin_v[2] = v2;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int av, input int bv, input longint cv, input logic [2:0] op,
                        input logic [2:0] pe, input longint v0, input longint v1, input longint v2);
        drive(1'b1, 1'b1, av, bv, cv, op, 1'b0, pe, v0, v1, v2);
    endtask

    task automatic idle(input logic ce_i, input logic clr);
        drive(1'b0, ce_i, 0, 0, 0, 3'b000, clr, 3'b000, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_p_lit", dp[0], 0);
        check("reset_valid_lit", ov_w[0], 0);
        rst_n = 1'b1;

        // Streaming, no ce gaps
        send(3, -4, 0, 3'b000, 3'b111, -12, -12, -12);
        send(5, 6, 100, 3'b001, 3'b111, 130, 130, 130);
        send(2, 2, 7, 3'b100, 3'b111, 7, 7, 7);
        repeat (4) idle(1'b1, 1'b0);
        check("stream_last_p_lit", dp[0], 7);

        // Accumulate with a bubble
        send(10, 10, 0, 3'b101, 3'b111, 0, 0, 0);
        send(10, 10, 0, 3'b010, 3'b111, 100, 100, 100);
        idle(1'b1, 1'b0);
        send(10, 10, 0, 3'b010, 3'b111, 200, 200, 200);
        send(10, 10, 0, 3'b010, 3'b111, 300, 300, 300);
        repeat (4) idle(1'b1, 1'b0);
        check("accum_p_lit", dp[0], 300);

        // Stall mid-stream: 4 cycles of ce=0, one of them with a sample presented
        send(3, -4, 0, 3'b000, 3'b001, -12, 0, 0);
        send(5, 6, 100, 3'b001, 3'b001, 130, 0, 0);
        drive(1'b1, 1'b0, 2, 2, 7, 3'b100, 1'b0, 3'b000, 0, 0, 0);
        repeat (3) idle(1'b0, 1'b0);
        send(2, 2, 7, 3'b100, 3'b001, 7, 0, 0);
        idle(1'b1, 1'b0);
        repeat (2) idle(1'b0, 1'b0);
        repeat (4) idle(1'b1, 1'b0);
        check("stall_p_lit", dp[0], 7);

        // Saturation / wrap on 36-bit instances
        send(-131072, -131072, 0, 3'b000, 3'b111, 64'sd17179869184, 64'sd17179869184, 64'sd17179869184);
        send(-131072, -131072, 0, 3'b010, 3'b111, 64'sd34359738368, 64'sd34359738367, -64'sd34359738368);
        repeat (4) idle(1'b1, 1'b0);
        check("sat_p_lit", dp[1], 64'sd34359738367);
        check("sat_ovf_lit", ovf_w[1], 1);
        check("sat_sticky_lit", stk_w[1], 1);
        check("wrap_p_lit", dp[2], -64'sd34359738368);
        check("wide_no_ovf_lit", ovf_w[0], 0);

        // Reset with two samples in flight
        send(1, 2, 0, 3'b000, 3'b000, 0, 0, 0);
        send(3, 4, 0, 3'b000, 3'b000, 0, 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_p_lit", dp[1], 0);
        check("async_rst_valid_lit", ov_w[0], 0);
        check("async_rst_ovf_lit", ovf_w[1], 0);
        check("async_rst_sticky_lit", stk_w[1], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) idle(1'b1, 1'b0);
        send(1, 1, 0, 3'b010, 3'b111, 1, 1, 1);
        repeat (4) idle(1'b1, 1'b0);
        check("post_rst_acc_lit", dp[0], 1);

        // Sticky set/clear race, then clear alone
        idle(1'b1, 1'b1);
        send(-131072, -131072, 0, 3'b000, 3'b000, 0, 0, 0);
        send(-131072, -131072, 0, 3'b010, 3'b000, 0, 0, 0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        check("race_sticky_lit", stk_w[1], 1);
        idle(1'b1, 1'b1);
        check("clr_sticky_lit", stk_w[1], 0);
        repeat (3) idle(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
